hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline stall scheduler for the five-stage core. Sits beside the ID stage and consumes the EX-stage write-back bus fields, ID read-port addresses, the EX multiply/divide start strobe and the MEM data-SRAM wait request. It arbitrates these stall sources into the single `stall[5:0]` vector that freezes the pipeline registers. Load-use hazards, which the forwarding network cannot cover, and multi-cycle mul/div occupancy are resolved here and nowhere else.

## Interface
- `DIV_LAT`, 33: total stall cycles for a divide (≥1)
- `MUL_LAT`, 2: total stall cycles for a multiply (≥1)
- `clk`  in  1  core clock, all state on rising edge
- `resetn`  in  1  reset, synchronous, active-low
- `ex_rf_we`  in  1  EX instruction writes the register file
- `ex_rf_waddr`  in  5  EX destination register
- `ex_is_load`  in  1  EX instruction is a load
- `id_re1`, `id_re2`  in  1 each  ID instruction reads port 1 / port 2
- `id_raddr1`, `id_raddr2`  in  5 each  ID source registers
- `ex_md_start`  in  1  EX instruction is mul/div, level while held in EX
- `ex_md_is_div`  in  1  qualifies `ex_md_start`: 1 = divide, 0 = multiply
- `mem_stall_req`  in  1  data SRAM not ready, MEM must hold
- `cnt_clr`  in  1  clears the stall-cycle counter
- `stall`  out  6  freeze vector; bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
- `md_busy`  out  1  mul/div sequence in progress
- `md_done`  out  1  one-cycle pulse: mul/div result valid in EX this cycle
- `stall_cycles`  out  32  saturating count of cycles with `stall[2]`=1

## Operation
- Stall rule: `stall[i]`=1 freezes stage i's input register. The first unfrozen stage downstream receives a bubble; the ID-to-EX stage does this.
- Load-use detect `lu` (combinational) = `ex_is_load & ex_rf_we & (ex_rf_waddr!=0) & ((id_re1 & id_raddr1==ex_rf_waddr) | (id_re2 & id_raddr2==ex_rf_waddr))`.
- FSM states: IDLE, BUSY. `cnt` is 6 bits wide.
  - IDLE with `ex_md_start`=1: load `cnt` = LAT-1 (DIV_LAT or MUL_LAT by `ex_md_is_div`). Go BUSY, except when LAT=1, which also goes BUSY with `cnt`=0. `md_stall`=1 this cycle.
  - BUSY with `cnt`!=0: `md_stall`=1. Decrement `cnt` unless `mem_stall_req`=1, which pauses it.
  - BUSY with `cnt`==0 and `mem_stall_req`=0: `md_done`=1, `md_stall`=0, go IDLE.
  - BUSY with `cnt`==0 and `mem_stall_req`=1: stay BUSY, `md_done`=0. Done is deferred, not lost.
  - `ex_md_start` is ignored in BUSY, including the done cycle, because EX still holds the same instruction.
- Priority (mutually exclusive outputs):
  - `mem_stall_req` gives `stall`=6'b011111.
  - Otherwise `md_stall` gives 6'b001111.
  - Otherwise `lu` gives 6'b000111.
  - Otherwise 6'b000000.
- `md_busy` = (state==BUSY).
- `stall_cycles` increments when `stall[2]`=1 and holds at 32'hFFFF_FFFF. `cnt_clr` has priority over increment: the next value is 0.

## Timing
- Reset (`resetn`=0 at an edge): state IDLE, `cnt`=0, `stall_cycles`=0. While `resetn`=0, `stall`=0, `md_busy`=0 and `md_done`=0, forced combinationally. Reset mid-BUSY aborts the sequence with no `md_done`.
- `stall` and `md_done` are combinational from inputs and current state, valid in the same cycle. `stall_cycles` updates at the next edge.
- Load-use costs exactly 1 stall cycle. The next cycle, EX holds a bubble (`ex_rf_we`=0), so `lu` deasserts without a state change.
- Mul/div with start at cycle T and no MEM waits: `stall`=001111 for cycles T..T+LAT-1, `md_done` at T+LAT with `stall`=0. Each MEM-wait cycle during BUSY delays `md_done` by one.
- Simultaneous `lu` and `ex_md_start` cannot occur, because EX holds a single instruction. If both are asserted, md wins.

## Test plan
- Load-use: `ex_is_load`=1, `ex_rf_we`=1, `ex_rf_waddr`=5, `id_re1`=1, `id_raddr1`=5, then next cycle `ex_rf_we`=0 -> `stall`=000111 for 1 cycle then 000000; `stall_cycles`=1.
- Zero-register immunity: same as above with `ex_rf_waddr`=0, `id_raddr1`=0, and a separate case with `id_re2`=0 matching port 2 -> `stall`=0 throughout.
- Divide, DIV_LAT=33: `ex_md_start`=1, `ex_md_is_div`=1 held -> 33 cycles of 001111, `md_done`=1 on cycle 34 only, `md_busy` high cycles 2..34, no restart on cycle 35 with a new start low.
- Multiply with MEM wait: MUL_LAT=2, `mem_stall_req`=1 on cycle 2 -> cycles 1..3 = 001111, 011111, 001111; `md_done` on cycle 4.
- Reset mid-divide: `resetn`=0 on cycle 10 of a divide, released on cycle 12 with `ex_md_start`=0 -> `stall`=0, `md_busy`=0, no `md_done`, `stall_cycles`=0.
- Counter saturation/clear: preload near 32'hFFFF_FFFE via a long MEM stall (force), stall 3 more cycles -> holds 32'hFFFF_FFFF; `cnt_clr`=1 with `stall[2]`=1 -> 0.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// Stall-scheduler bus: EX/ID hazard fields in, freeze vector and
// mul/div status out.
interface hazard_stall_ctrl_if;
  logic        ex_rf_we;
  logic [4:0]  ex_rf_waddr;
  logic        ex_is_load;
  logic        id_re1;
  logic        id_re2;
  logic [4:0]  id_raddr1;
  logic [4:0]  id_raddr2;
  logic        ex_md_start;
  logic        ex_md_is_div;
  logic        mem_stall_req;
  logic        cnt_clr;
  logic [5:0]  stall;
  logic        md_busy;
  logic        md_done;
  logic [31:0] stall_cycles;

  modport master (
    output ex_rf_we, ex_rf_waddr, ex_is_load,
    output id_re1, id_re2, id_raddr1, id_raddr2,
    output ex_md_start, ex_md_is_div,
    output mem_stall_req, cnt_clr,
    input  stall, md_busy, md_done, stall_cycles
  );

  modport slave (
    input  ex_rf_we, ex_rf_waddr, ex_is_load,
    input  id_re1, id_re2, id_raddr1, id_raddr2,
    input  ex_md_start, ex_md_is_div,
    input  mem_stall_req, cnt_clr,
    output stall, md_busy, md_done, stall_cycles
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall scheduler: load-use, mul/div occupancy and MEM wait
// merged into one freeze vector, plus a saturating stall counter.
module hazard_stall_ctrl #(
  parameter int unsigned DIV_LAT = 33,
  parameter int unsigned MUL_LAT = 2
) (
  input logic               clk,
  input logic               resetn,
  hazard_stall_ctrl_if.slave bus
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);
  localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;

  logic        hit1;
  logic        hit2;
  logic        lu;
  logic        md_stall;
  logic        md_done;
  logic [5:0]  stall;

  assign hit1 = bus.id_re1 &&
                (bus.id_raddr1 == bus.ex_rf_waddr);
  assign hit2 = bus.id_re2 &&
                (bus.id_raddr2 == bus.ex_rf_waddr);

  assign lu = bus.ex_is_load && bus.ex_rf_we &&
              (bus.ex_rf_waddr != 5'd0) &&
              (hit1 || hit2);

  always_comb begin
    md_stall = 1'b0;
    md_done  = 1'b0;
    unique case (state_q)
      IDLE: md_stall = bus.ex_md_start;
      BUSY: begin
        md_stall = (cnt_q != 6'd0);
        md_done  = (cnt_q == 6'd0) && !bus.mem_stall_req;
      end
      default: ;
    endcase
  end

  always_comb begin
    stall = 6'b000000;
    if (!resetn)
      stall = 6'b000000;
    else if (bus.mem_stall_req)
      stall = 6'b011111;
    else if (md_stall)
      stall = 6'b001111;
    else if (lu)
      stall = 6'b000111;
  end

  assign bus.stall   = stall;
  assign bus.md_busy = resetn && (state_q == BUSY);
  assign bus.md_done = resetn && md_done;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.ex_md_start) begin
            cnt_q   <= bus.ex_md_is_div ? DIV_CNT
                                        : MUL_CNT;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          // a MEM wait freezes EX, so the sequence pauses with it
          if (cnt_q != 6'd0) begin
            if (!bus.mem_stall_req)
              cnt_q <= cnt_q - 6'd1;
          end else if (!bus.mem_stall_req) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (bus.cnt_clr)
      stall_cycles_d = 32'd0;
    else if (stall[2] && (stall_cycles_q != 32'hFFFF_FFFF))
      stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn)
      stall_cycles_q <= 32'd0;
    else
      stall_cycles_q <= stall_cycles_d;
  end

  assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: load-use, zero-reg immunity,
// divide/multiply timing, MEM pauses, reset abort, counter saturation.
module tb_hazard_stall_ctrl;

  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_bad;

  hazard_stall_ctrl_if bus ();

  hazard_stall_ctrl #(
    .DIV_LAT (33),
    .MUL_LAT (2)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // settle combinational outputs mid-cycle
  task automatic mid();
    #3;
  endtask

  task automatic idle_in();
    bus.ex_rf_we       = 1'b0;
    bus.ex_rf_waddr    = 5'd0;
    bus.ex_is_load     = 1'b0;
    bus.id_re1         = 1'b0;
    bus.id_re2         = 1'b0;
    bus.id_raddr1      = 5'd0;
    bus.id_raddr2      = 5'd0;
    bus.ex_md_start    = 1'b0;
    bus.ex_md_is_div   = 1'b0;
    bus.mem_stall_req  = 1'b0;
    bus.cnt_clr        = 1'b0;
  endtask

  task automatic load_ex(input logic [4:0] wa);
    bus.ex_is_load  = 1'b1;
    bus.ex_rf_we    = 1'b1;
    bus.ex_rf_waddr = wa;
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    idle_in();
    resetn = 1'b0;
    bus.ex_md_start = 1'b1;
    tick();
    tick();
    mid();
    chk("rst_stall", {26'd0, bus.stall}, 32'd0);
    chk("rst_busy", {31'd0, bus.md_busy}, 32'd0);
    chk("rst_done", {31'd0, bus.md_done}, 32'd0);
    chk("rst_cnt", bus.stall_cycles, 32'd0);
    idle_in();
    resetn = 1'b1;
    tick();

    // load-use on port 1
    load_ex(5'd5);
    bus.id_re1    = 1'b1;
    bus.id_raddr1 = 5'd5;
    mid();
    chk("lu_stall", {26'd0, bus.stall}, 32'h07);
    tick();
    bus.ex_rf_we = 1'b0;
    mid();
    chk("lu_bubble", {26'd0, bus.stall}, 32'h00);
    chk("lu_cnt", bus.stall_cycles, 32'd1);
    tick();

    // x0 is never a hazard
    load_ex(5'd0);
    bus.id_re1    = 1'b1;
    bus.id_raddr1 = 5'd0;
    mid();
    chk("lu_x0", {26'd0, bus.stall}, 32'h00);
    tick();

    // port 2 match without its read enable
    idle_in();
    load_ex(5'd9);
    bus.id_re2    = 1'b0;
    bus.id_raddr2 = 5'd9;
    mid();
    chk("lu_re2_off", {26'd0, bus.stall}, 32'h00);
    tick();
    bus.id_re2 = 1'b1;
    mid();
    chk("lu_port2", {26'd0, bus.stall}, 32'h07);
    tick();
    bus.ex_is_load = 1'b0;
    mid();
    chk("lu_noload", {26'd0, bus.stall}, 32'h00);
    chk("lu_cnt2", bus.stall_cycles, 32'd2);

    // clear counter before the divide
    idle_in();
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    mid();
    chk("clr_idle", bus.stall_cycles, 32'd0);
    tick();

    // divide, 33 stall cycles
    bus.ex_md_start  = 1'b1;
    bus.ex_md_is_div = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      mid();
      chk($sformatf("div_stall_c%0d", i),
          {26'd0, bus.stall}, 32'h0F);
      chk($sformatf("div_busy_c%0d", i),
          {31'd0, bus.md_busy}, (i >= 2) ? 32'd1 : 32'd0);
      chk($sformatf("div_done_c%0d", i),
          {31'd0, bus.md_done}, 32'd0);
      tick();
    end
    mid();
    chk("div_c34_stall", {26'd0, bus.stall}, 32'h00);
    chk("div_c34_done", {31'd0, bus.md_done}, 32'd1);
    chk("div_c34_busy", {31'd0, bus.md_busy}, 32'd1);
    tick();
    bus.ex_md_start = 1'b0;
    mid();
    chk("div_c35_busy", {31'd0, bus.md_busy}, 32'd0);
    chk("div_c35_done", {31'd0, bus.md_done}, 32'd0);
    chk("div_c35_stall", {26'd0, bus.stall}, 32'h00);
    chk("div_cnt", bus.stall_cycles, 32'd33);
    tick();

    // multiply with MEM wait on cycle 2
    bus.ex_md_start  = 1'b1;
    bus.ex_md_is_div = 1'b0;
    mid();
    chk("mul_c1", {26'd0, bus.stall}, 32'h0F);
    tick();
    bus.mem_stall_req = 1'b1;
    mid();
    chk("mul_c2", {26'd0, bus.stall}, 32'h1F);
    chk("mul_c2_busy", {31'd0, bus.md_busy}, 32'd1);
    tick();
    bus.mem_stall_req = 1'b0;
    mid();
    chk("mul_c3", {26'd0, bus.stall}, 32'h0F);
    chk("mul_c3_done", {31'd0, bus.md_done}, 32'd0);
    tick();
    mid();
    chk("mul_c4", {26'd0, bus.stall}, 32'h00);
    chk("mul_c4_done", {31'd0, bus.md_done}, 32'd1);
    tick();
    bus.ex_md_start = 1'b0;
    mid();
    chk("mul_c5_busy", {31'd0, bus.md_busy}, 32'd0);
    tick();

    // MEM wait on the would-be done cycle defers md_done
    bus.ex_md_start = 1'b1;
    tick();
    tick();
    bus.mem_stall_req = 1'b1;
    mid();
    chk("defer_stall", {26'd0, bus.stall}, 32'h1F);
    chk("defer_done0", {31'd0, bus.md_done}, 32'd0);
    tick();
    bus.mem_stall_req = 1'b0;
    mid();
    chk("defer_done1", {31'd0, bus.md_done}, 32'd1);
    chk("defer_stall0", {26'd0, bus.stall}, 32'h00);
    tick();
    bus.ex_md_start = 1'b0;
    tick();

    // md wins over a simultaneous load-use
    load_ex(5'd3);
    bus.id_re1      = 1'b1;
    bus.id_raddr1   = 5'd3;
    bus.ex_md_start = 1'b1;
    mid();
    chk("md_over_lu", {26'd0, bus.stall}, 32'h0F);

    // reset in the middle of a divide
    idle_in();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    bus.ex_md_start  = 1'b1;
    bus.ex_md_is_div = 1'b1;
    for (int i = 1; i <= 9; i++) tick();
    resetn = 1'b0;
    mid();
    chk("rmid_stall", {26'd0, bus.stall}, 32'h00);
    chk("rmid_busy", {31'd0, bus.md_busy}, 32'd0);
    chk("rmid_done", {31'd0, bus.md_done}, 32'd0);
    tick();
    bus.ex_md_start = 1'b0;
    tick();
    resetn = 1'b1;
    mid();
    chk("rrel_stall", {26'd0, bus.stall}, 32'h00);
    chk("rrel_busy", {31'd0, bus.md_busy}, 32'd0);
    chk("rrel_done", {31'd0, bus.md_done}, 32'd0);
    chk("rrel_cnt", bus.stall_cycles, 32'd0);
    tick();
    mid();
    chk("rrel_busy2", {31'd0, bus.md_busy}, 32'd0);
    tick();

    // saturation then clear
    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cycles_q;
    bus.mem_stall_req = 1'b1;
    tick();
    chk("sat_1", bus.stall_cycles, 32'hFFFF_FFFF);
    tick();
    tick();
    chk("sat_3", bus.stall_cycles, 32'hFFFF_FFFF);
    bus.cnt_clr = 1'b1;
    tick();
    chk("clr_stall", bus.stall_cycles, 32'd0);
    bus.cnt_clr = 1'b0;
    tick();
    chk("post_clr", bus.stall_cycles, 32'd1);

    idle_in();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
